// File: rtl/fetch_unit.sv
// ============================================================================
// fetch_unit : single-issue instruction fetch stage for a 1-cycle-latency memory
// Optional macro FETCH_COUNT_EN adds the fetch_count output. Rev 1.0
// ============================================================================
`default_nettype none

module fetch_unit #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 14,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [DATA_W-1:0] mem_dataout,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_en,
  output logic [DATA_W-1:0] mem_datain,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              running
`ifdef FETCH_COUNT_EN
  ,
  output logic [15:0]       fetch_count
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
  logic                instr_valid_q, instr_valid_d;
  logic                running_q, running_d;
  logic                accept;
  logic                start_ok;

  // Priority outside IDLE: stop, then jump, then the normal fetch sequence.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;
    accept        = 1'b0;
    start_ok      = 1'b0;
    if (state_q == IDLE) begin
      if (start) begin
        start_ok = 1'b1;
        pc_d     = PC_INIT;
        state_d  = ISSUE;
      end
    end else if (stop) begin
      instr_valid_d = 1'b0;
      state_d       = IDLE;
    end else if (jump_valid) begin
      pc_d          = jump_target;
      instr_valid_d = 1'b0;
      state_d       = ISSUE;
    end else begin
      case (state_q)
        ISSUE: state_d = CAPTURE;
        CAPTURE: begin
          instr_d       = mem_dataout;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + ADDR_W'(1);
          state_d       = HOLD;
        end
        HOLD: begin
          if (instr_ready) begin
            accept        = 1'b1;
            instr_valid_d = 1'b0;
            state_d       = ISSUE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= PC_INIT;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
      running_q     <= running_d;
    end
  end

`ifdef FETCH_COUNT_EN
  logic [15:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (start_ok) begin
      fetch_count_d = '0;
    end else if (accept && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
`else
  logic unused_ok;
  assign unused_ok = accept ^ start_ok;
`endif

  // Read-only stage: the write side of the memory port is tied off.
  assign mem_address = pc_q;
  assign mem_en      = 1'b0;
  assign mem_datain  = '0;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign running     = running_q;

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, memory address width.
REQ-002 SHALL have parameter DATA_W, default 14, memory word and instruction width.
REQ-003 SHALL have parameter RESET_PC, default 0, PC value loaded on reset and on start.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  begin fetching from RESET_PC (sampled in IDLE only).
REQ-007 SHALL have port stop  input  1  abort fetching, return to IDLE.
REQ-008 SHALL have port jump_valid  input  1  redirect PC request.
REQ-009 SHALL have port jump_target  input  ADDR_W  redirect address.
REQ-010 SHALL have port mem_dataout  input  DATA_W  read data from the memory block.
REQ-011 SHALL have port instr_ready  input  1  downstream accepts instr this cycle.
REQ-012 SHALL have port mem_address  output  ADDR_W  memory address, driven directly from the PC register.
REQ-013 SHALL have port mem_en  output  1  memory write enable, constant 0 (read-only stage).
REQ-014 SHALL have port mem_datain  output  DATA_W  memory write data, constant 0.
REQ-015 SHALL have port instr  output  DATA_W  fetched word, registered.
REQ-016 SHALL have port instr_pc  output  ADDR_W  address instr was fetched from.
REQ-017 SHALL have port instr_valid  output  1  instr/instr_pc hold a valid word.
REQ-018 SHALL have port running  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, CAPTURE, HOLD; memory read latency is one cycle (data valid in the cycle after the address is presented).
REQ-020 IDLE: on start=1, SHALL load pc<=RESET_PC and go to ISSUE; jump_valid is ignored in IDLE.
REQ-021 ISSUE: mem_address=pc; SHALL go to CAPTURE unconditionally next edge.
REQ-022 CAPTURE: SHALL load instr<=mem_dataout, instr_pc<=pc, instr_valid<=1, pc<=pc+1 modulo 2^ADDR_W (31 wraps to 0), then go to HOLD.
REQ-023 HOLD: instr, instr_pc, instr_valid SHALL stay stable while instr_ready=0; on instr_ready=1 SHALL clear instr_valid and go to ISSUE next edge.
REQ-024 Minimum issue interval with instr_ready held high SHALL be 3 cycles per instruction.
REQ-025 jump_valid=1 in ISSUE/CAPTURE/HOLD SHALL set pc<=jump_target, clear instr_valid, discard any in-flight capture, and go to ISSUE; jump overrides instr_ready and CAPTURE loading.
REQ-026 stop=1 in any non-IDLE state SHALL clear instr_valid and go to IDLE, pc held; stop beats jump_valid and start when simultaneous.
REQ-027 start asserted outside IDLE SHALL be ignored.
REQ-028 instr and instr_pc SHALL retain their last values when instr_valid drops (no clearing except at reset).

Reset
REQ-029 rst_n=0 SHALL immediately, independent of clk, force state=IDLE, pc=RESET_PC, instr=0, instr_pc=0, instr_valid=0, running=0 (and fetch_count=0 when present).
REQ-030 Reset mid-fetch SHALL abandon the transaction; the first edge after rst_n rises SHALL see IDLE behaviour.

Configuration
REQ-031 With macro FETCH_COUNT_EN defined, SHALL add output fetch_count [15:0], incremented on each HOLD cycle with instr_ready=1 and jump_valid=0 and stop=0, saturating at 16'hFFFF, cleared on reset and on start accepted in IDLE.
REQ-032 Without FETCH_COUNT_EN, fetch_count port and its logic SHALL not exist; all other behaviour identical.

Verification
REQ-033 Memory model preloaded addr0=14'h0011, addr1=14'h0022; rst_n pulse, start 1 cycle, instr_ready=1 -> instr_valid high with instr=14'h0011/instr_pc=0 on 3rd cycle after start, then 14'h0022/instr_pc=1 three cycles later.
REQ-034 instr_ready=0 for 5 cycles during HOLD -> instr=14'h0011 and instr_valid stable all 5 cycles, mem_address=1 held, no new ISSUE.
REQ-035 jump_valid=1, jump_target=5'd20 during CAPTURE -> captured word discarded, instr_valid=0, next delivered instr_pc=20.
REQ-036 jump_target=5'd31, addr31=14'h3FFF -> instr=14'h3FFF, instr_pc=31, next mem_address=0 (wrap).
REQ-037 stop and jump_valid together in HOLD -> IDLE, instr_valid=0, running=0, pc unchanged; rst_n=0 mid-CAPTURE -> all outputs zero asynchronously, mem_en=0 throughout.
REQ-038 With FETCH_COUNT_EN: 4 accepted instructions plus 1 jump-squashed fetch -> fetch_count=4; new start from IDLE -> 0.
